// File: rtl/trig_l2_pkg.sv
// rtl/trig_l2_pkg.sv - shared widths, FSM states and activation limit for trigger_layer_2
//
// Purpose: common definitions imported by trigger_layer_2 and relu_requant.
// Ports: none (package).

package trig_l2_pkg;

  localparam int ACT_W = 8;   // requantized activation width
  localparam int NIN_W = 16;  // hidden-layer neuron result width
  localparam int ACC_W = 20;  // accumulator / score width

  // Activations saturate here so they always fit a positive signed byte.
  localparam logic [NIN_W-1:0] ACT_SAT = 16'd127;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC1,
    ST_MAC2,
    ST_MAC3,
    ST_OUT
  } state_t;

endpackage

// File: rtl/trigger_layer_2_relu_requant.sv
// rtl/trigger_layer_2_relu_requant.sv - ReLU, arithmetic shift and saturation for one neuron
//
// Purpose: a = min(max(n, 0) >>> SHIFT, 127), purely combinational.
// Ports:
//   n  in  16 signed : hidden-layer neuron result
//   a  out  8 signed : activation, always in 0..127

module relu_requant
  import trig_l2_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic signed [NIN_W-1:0] n,
  output logic signed [ACT_W-1:0] a
);

  logic [NIN_W-1:0] shifted;

  // Negative inputs clamp to zero before the shift, so the shifted value is
  // always non-negative and can be compared as unsigned.
  assign shifted = n[NIN_W-1] ? '0 : $unsigned(n >>> SHIFT);

  assign a = (shifted > ACT_SAT) ? ACT_SAT[ACT_W-1:0] : shifted[ACT_W-1:0];

endmodule

// File: rtl/trigger_layer_2.sv
// rtl/trigger_layer_2.sv - L1 trigger output layer: ReLU/requant, 3-cycle shared MAC, threshold
//
// Purpose: accept three hidden-layer results, compute
//   score = BIAS + a1*W1 + a2*W2 + a3*W3 with one multiplier over three
//   cycles, and flag trigger when score > THRESHOLD.
// Optional feature: define TRIG_L2_HIT_COUNT_EN to enable the saturating
//   hit counter; otherwise hit_count is tied to zero.
// Ports:
//   clk        in  1         : clock, rising edge
//   rst        in  1         : asynchronous active-low reset
//   in_valid   in  1         : n*_in valid
//   in_ready   out 1         : block idle and can accept
//   n1_in..n3_in in 16 signed: hidden-layer neuron results
//   out_valid  out 1         : score/trigger valid
//   out_ready  in  1         : consumer takes the result
//   score      out 20 signed : accumulated sum
//   trigger    out 1         : score > THRESHOLD
//   hit_count  out 16        : saturating count of accepted triggers

module trigger_layer_2
  import trig_l2_pkg::*;
#(
  parameter int                      SHIFT     = 4,
  parameter logic signed [ACT_W-1:0] W1        = 8'sd40,
  parameter logic signed [ACT_W-1:0] W2        = -8'sd25,
  parameter logic signed [ACT_W-1:0] W3        = 8'sd30,
  parameter logic signed [ACT_W-1:0] BIAS      = -8'sd10,
  parameter logic signed [ACC_W-1:0] THRESHOLD = 20'sd500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [NIN_W-1:0] n1_in,
  input  logic signed [NIN_W-1:0] n2_in,
  input  logic signed [NIN_W-1:0] n3_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] score,
  output logic                    trigger,
  output logic [15:0]             hit_count
);

  state_t state_q, state_d;

  logic signed [ACT_W-1:0] act1, act2, act3;
  logic signed [ACT_W-1:0] a1_q, a2_q, a3_q;
  logic signed [ACC_W-1:0] acc_q;

  logic signed [ACT_W-1:0] a_sel, w_sel;
  logic [2*ACT_W-1:0]      prod_raw;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] bias_ext;

  relu_requant #(.SHIFT(SHIFT)) u_rq1 (.n(n1_in), .a(act1));
  relu_requant #(.SHIFT(SHIFT)) u_rq2 (.n(n2_in), .a(act2));
  relu_requant #(.SHIFT(SHIFT)) u_rq3 (.n(n3_in), .a(act3));

  // Reset forces in_ready low even though the state register already sits in IDLE.
  assign in_ready  = rst && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_MAC1;
      ST_MAC1: state_d = ST_MAC2;
      ST_MAC2: state_d = ST_MAC3;
      ST_MAC3: state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand select for the single shared multiplier.
  always_comb begin
    a_sel = a1_q;
    w_sel = W1;
    case (state_q)
      ST_MAC2: begin a_sel = a2_q; w_sel = W2; end
      ST_MAC3: begin a_sel = a3_q; w_sel = W3; end
      default: ;
    endcase
  end

  // Operands are sign-extended to 16 bits so the low 16 bits of the
  // unsigned product equal the signed 8x8 product.
  assign prod_raw = {{ACT_W{a_sel[ACT_W-1]}}, a_sel} * {{ACT_W{w_sel[ACT_W-1]}}, w_sel};
  assign prod_ext = {{(ACC_W-2*ACT_W){prod_raw[2*ACT_W-1]}}, prod_raw};
  assign acc_sum  = acc_q + prod_ext;
  assign bias_ext = {{(ACC_W-ACT_W){BIAS[ACT_W-1]}}, BIAS};

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      acc_q   <= '0;
      score   <= '0;
      trigger <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a1_q  <= act1;
            a2_q  <= act2;
            a3_q  <= act3;
            acc_q <= bias_ext;
          end
        end
        ST_MAC1, ST_MAC2: acc_q <= acc_sum;
        ST_MAC3: begin
          acc_q   <= acc_sum;
          score   <= acc_sum;
          trigger <= (acc_sum > THRESHOLD);
        end
        default: ;
      endcase
    end
  end

`ifdef TRIG_L2_HIT_COUNT_EN
  logic [15:0] hit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q <= '0;
    end else if (out_valid && out_ready && trigger && (hit_q != 16'hFFFF)) begin
      hit_q <= hit_q + 16'd1;
    end
  end

  assign hit_count = hit_q;
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_trigger_layer_2.sv
// tb/tb_trigger_layer_2.sv - self-checking bench for trigger_layer_2

module tb_trigger_layer_2;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] n1_in, n2_in, n3_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [19:0] score;
  logic               trigger;
  logic [15:0]        hit_count;

  int tests_run;
  int tests_failed;
  int exp_hits;

`ifdef TRIG_L2_HIT_COUNT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  trigger_layer_2 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n1_in     (n1_in),
    .n2_in     (n2_in),
    .n3_in     (n3_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .score     (score),
    .trigger   (trigger),
    .hit_count (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] n1;
    logic signed [15:0] n2;
    logic signed [15:0] n3;
    int                 exp_score;
    logic               exp_trig;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present one event at the next negedge, measure acceptance-to-valid
  // latency in clock edges, check the result, then complete the handshake.
  task automatic run_event(input string name,
                           input logic signed [15:0] a, input logic signed [15:0] b,
                           input logic signed [15:0] c,
                           input int exp_score, input logic exp_trig);
    int lat;
    @(negedge clk);
    n1_in = a; n2_in = b; n3_in = c;
    in_valid = 1'b1;
    check({name, " in_ready"}, int'(in_ready), 1);
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid || lat > 20) break;
    end
    check({name, " latency"}, lat, 4);
    check({name, " score"}, int'(score), exp_score);
    check({name, " trigger"}, int'(trigger), int'(exp_trig));
    out_ready = 1'b1;
    @(posedge clk);
    if (HIT_EN && exp_trig) exp_hits++;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid cleared"}, int'(out_valid), 0);
    check({name, " in_ready again"}, int'(in_ready), 1);
    check({name, " hit_count"}, int'(hit_count), exp_hits);
  endtask

  initial begin
    int lat;
    logic signed [19:0] held_score;

    tests_run = 0; tests_failed = 0; exp_hits = 0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n1_in = '0; n2_in = '0; n3_in = '0;

    vecs[0]  = '{16'sd1600,   -16'sd300, 16'sd800, 5490,  1'b1};
    vecs[1]  = '{16'sd0,      16'sd1600, 16'sd0,   -2510, 1'b0};
    vecs[2]  = '{16'sd0,      16'sd0,    16'sd0,   -10,   1'b0};
    vecs[3]  = '{16'sd32767,  16'sd0,    16'sd0,   5070,  1'b1};
    vecs[4]  = '{16'sd0,      16'sd0,    16'sd272, 500,   1'b0};
    vecs[5]  = '{16'sd0,      16'sd0,    16'sd288, 530,   1'b1};
    vecs[6]  = '{-16'sd32768, -16'sd1,   -16'sd5,  -10,   1'b0};
    vecs[7]  = '{16'sd0,      16'sd32767,16'sd0,   -3185, 1'b0};
    vecs[8]  = '{16'sd2047,   16'sd0,    16'sd0,   5070,  1'b1};
    vecs[9]  = '{16'sd15,     16'sd15,   16'sd15,  -10,   1'b0};
    vecs[10] = '{16'sd16,     16'sd16,   16'sd16,  35,    1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset in_ready", int'(in_ready), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset score", int'(score), 0);
    check("reset trigger", int'(trigger), 0);
    check("reset hit_count", int'(hit_count), 0);
    rst = 1'b1;
    #1;
    check("release in_ready", int'(in_ready), 1);

    for (int i = 0; i < 11; i++) begin
      run_event($sformatf("vec%0d", i), vecs[i].n1, vecs[i].n2, vecs[i].n3,
                vecs[i].exp_score, vecs[i].exp_trig);
    end

    // Reset in the middle of MAC2 must abort with no result.
    @(negedge clk);
    n1_in = 16'sd1600; n2_in = -16'sd300; n3_in = 16'sd800;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_hits = 0;
    check("midreset out_valid", int'(out_valid), 0);
    check("midreset score", int'(score), 0);
    check("midreset trigger", int'(trigger), 0);
    check("midreset in_ready", int'(in_ready), 0);
    check("midreset hit_count", int'(hit_count), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post-reset in_ready", int'(in_ready), 1);
    repeat (6) @(negedge clk);
    check("no partial result", int'(out_valid), 0);

    run_event("after reset", 16'sd0, 16'sd0, 16'sd288, 530, 1'b1);

    // Backpressure: result held while a second input waits.
    @(negedge clk);
    n1_in = 16'sd1600; n2_in = -16'sd300; n3_in = 16'sd800;
    in_valid = 1'b1;
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        n1_in = 16'sd0; n2_in = 16'sd1600; n3_in = 16'sd0;
      end
      if (out_valid || lat > 20) break;
    end
    check("bp latency", lat, 4);
    held_score = score;
    check("bp score", int'(held_score), 5490);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp hold score c%0d", c), int'(score), 5490);
      check($sformatf("bp hold trigger c%0d", c), int'(trigger), 1);
      check($sformatf("bp hold valid c%0d", c), int'(out_valid), 1);
      check($sformatf("bp in_ready c%0d", c), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    if (HIT_EN) exp_hits++;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp handshake valid", int'(out_valid), 0);
    check("bp second waiting", int'(in_ready), 1);
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid || lat > 20) break;
    end
    check("bp2 latency", lat, 4);
    check("bp2 score", int'(score), -2510);
    check("bp2 trigger", int'(trigger), 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp2 out_valid cleared", int'(out_valid), 0);
    check("final hit_count", int'(hit_count), exp_hits);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
